// File: rtl/alu16_sequencer.sv
// alu16_sequencer: drives a shared 8-bit adder low byte then high byte to build 16-bit ADD/ADDSP/INC/DEC results and flags
module alu16_sequencer #(
    parameter int DONE_PULSE = 1
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    input  logic [1:0]  i_Op,
    input  logic [15:0] i_Operand_A,
    input  logic [15:0] i_Operand_B,
    output logic [7:0]  o_Adder_A,
    output logic [7:0]  o_Adder_B,
    output logic        o_Adder_Cin,
    input  logic [7:0]  i_Adder_Sum,
    input  logic        i_Adder_Carry,
    input  logic        i_Adder_HalfCarry,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [15:0] o_Result,
    output logic [3:0]  o_Flags,
    output logic [3:0]  o_Flag_Mask
);
    localparam logic [1:0] OP_ADD16 = 2'b00;
    localparam logic [1:0] OP_ADDSP = 2'b01;
    localparam logic [1:0] OP_INC16 = 2'b10;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [7:0]  lo_q, lo_d;
    logic        c_lo_q, c_lo_d, h_lo_q, h_lo_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d, mask_q, mask_d;
    logic        done_q, done_d;
    logic [15:0] eff_b;

    assign eff_b = (i_Op == OP_ADD16) ? i_Operand_B :
                   (i_Op == OP_ADDSP) ? {{8{i_Operand_B[7]}}, i_Operand_B[7:0]} :
                   (i_Op == OP_INC16) ? 16'h0000 : 16'hFFFF;

    // Next-state, adder drive and result/flag capture for the IDLE -> LOW -> HIGH sequence
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        lo_d        = lo_q;
        c_lo_d      = c_lo_q;
        h_lo_d      = h_lo_q;
        result_d    = result_q;
        flags_d     = flags_q;
        mask_d      = mask_q;
        done_d      = (DONE_PULSE != 0) ? 1'b0 : done_q;
        o_Adder_A   = 8'h00;
        o_Adder_B   = 8'h00;
        o_Adder_Cin = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_Start) begin
                    state_d = LOW;
                    op_d    = i_Op;
                    a_d     = i_Operand_A;
                    b_d     = eff_b;
                    done_d  = 1'b0;
                end
            end
            LOW: begin
                o_Adder_A   = a_q[7:0];
                o_Adder_B   = b_q[7:0];
                o_Adder_Cin = (op_q == OP_INC16);
                lo_d        = i_Adder_Sum;
                c_lo_d      = i_Adder_Carry;
                h_lo_d      = i_Adder_HalfCarry;
                state_d     = HIGH;
            end
            HIGH: begin
                o_Adder_A   = a_q[15:8];
                o_Adder_B   = b_q[15:8];
                o_Adder_Cin = c_lo_q;
                result_d    = {i_Adder_Sum, lo_q};
                flags_d     = (op_q == OP_ADD16) ? {2'b00, i_Adder_HalfCarry, i_Adder_Carry} :
                              (op_q == OP_ADDSP) ? {2'b00, h_lo_q, c_lo_q} : 4'b0000;
                mask_d      = (op_q == OP_ADD16) ? 4'b0111 :
                              (op_q == OP_ADDSP) ? 4'b1111 : 4'b0000;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial operation
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            lo_q     <= 8'h00;
            c_lo_q   <= 1'b0;
            h_lo_q   <= 1'b0;
            result_q <= 16'h0000;
            flags_q  <= 4'h0;
            mask_q   <= 4'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lo_q     <= lo_d;
            c_lo_q   <= c_lo_d;
            h_lo_q   <= h_lo_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
        end
    end

    assign o_Busy      = (state_q != IDLE);
    assign o_Done      = done_q;
    assign o_Result    = result_q;
    assign o_Flags     = flags_q;
    assign o_Flag_Mask = mask_q;
endmodule

// File: tb/tb_alu16_sequencer.sv
// tb_alu16_sequencer: directed checks of alu16_sequencer against a behavioural 8-bit adder
module tb_alu16_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [1:0]  op;
    logic [15:0] opa, opb;
    logic [7:0]  adder_a, adder_b, adder_sum;
    logic        adder_cin, adder_carry, adder_hc;
    logic        busy, done;
    logic [15:0] result;
    logic [3:0]  flags, mask;
    logic [4:0]  lo_nib;
    int          n_chk = 0;
    int          n_err = 0;
    logic [5:0]  done_seq;

    alu16_sequencer dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Op(op),
        .i_Operand_A(opa), .i_Operand_B(opb),
        .o_Adder_A(adder_a), .o_Adder_B(adder_b), .o_Adder_Cin(adder_cin),
        .i_Adder_Sum(adder_sum), .i_Adder_Carry(adder_carry), .i_Adder_HalfCarry(adder_hc),
        .o_Busy(busy), .o_Done(done), .o_Result(result), .o_Flags(flags), .o_Flag_Mask(mask)
    );

    assign {adder_carry, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'h00, adder_cin};
    assign lo_nib   = {1'b0, adder_a[3:0]} + {1'b0, adder_b[3:0]} + {4'h0, adder_cin};
    assign adder_hc = lo_nib[4];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic [3:0] exp_flags, input logic [3:0] exp_mask);
        start = 1'b1; op = o; opa = a; opb = b;
        tick();
        start = 1'b0; opa = 16'hDEAD; opb = 16'hBEEF;
        chk({tag, "_busy_low"}, busy, 1);
        chk({tag, "_done_low"}, done, 0);
        tick();
        chk({tag, "_busy_high"}, busy, 1);
        chk({tag, "_done_high"}, done, 0);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_flags"}, flags, exp_flags);
        chk({tag, "_mask"}, mask, exp_mask);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; opa = 16'h0; opb = 16'h0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_mask", mask, 0);
        chk("idle_adder", {adder_a, adder_b, 7'b0, adder_cin}, 0);
        rst_n = 1'b1;
        tick();

        run_op("add16_h",  2'b00, 16'h0FFF, 16'h0001, 16'h1000, 4'b0010, 4'b0111);
        run_op("add16_c",  2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011, 4'b0111);
        run_op("addsp_p",  2'b01, 16'h00FF, 16'h0001, 16'h0100, 4'b0011, 4'b1111);
        run_op("addsp_n",  2'b01, 16'h0000, 16'h00FF, 16'hFFFF, 4'b0000, 4'b1111);
        run_op("dec16",    2'b11, 16'h0000, 16'h1234, 16'hFFFF, 4'b0000, 4'b0000);

        // INC16 with explicit adder-drive checks in LOW and HIGH
        start = 1'b1; op = 2'b10; opa = 16'hFFFF; opb = 16'h5555;
        tick();
        start = 1'b0;
        chk("inc_low_a", adder_a, 8'hFF);
        chk("inc_low_b", adder_b, 8'h00);
        chk("inc_low_cin", adder_cin, 1);
        tick();
        chk("inc_high_a", adder_a, 8'hFF);
        chk("inc_high_b", adder_b, 8'h00);
        chk("inc_high_cin", adder_cin, 1);
        tick();
        chk("inc_done", done, 1);
        chk("inc_result", result, 16'h0000);
        chk("inc_flags", flags, 4'b0000);
        chk("inc_mask", mask, 4'b0000);
        chk("inc_idle_adder", {adder_a, adder_b, 7'b0, adder_cin}, 0);
        tick();

        // start held for six edges: accepts at edge 0 and 3 only
        start = 1'b1; op = 2'b00; opa = 16'h1234; opb = 16'h1111;
        done_seq = 6'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            done_seq[k] = done;
            if (k == 2 || k == 5) chk($sformatf("held_result_%0d", k), result, 16'h2345);
        end
        start = 1'b0;
        chk("held_done_seq", done_seq, 6'b100100);
        tick();
        chk("held_no_third_busy", busy, 0);
        tick();
        chk("held_no_third_done", done, 0);

        // reset while in HIGH discards the operation
        start = 1'b1; op = 2'b00; opa = 16'h0FFF; opb = 16'h0001;
        tick();
        start = 1'b0;
        tick();
        chk("mid_in_high", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 16'h0000);
        chk("mid_rst_flags", flags, 4'h0);
        tick();
        chk("mid_rst_stays_idle", busy, 0);
        run_op("post_rst", 2'b00, 16'h1234, 16'h1111, 16'h2345, 4'b0000, 4'b0111);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
